mem_dump_unit: RTL and testbench

Post-run readout stage sitting directly downstream of the EnDMe top level. When the processor raises its done flag, this block walks a window of data memory through a read port and streams each byte out over a valid/ready interface. It also produces a running checksum, so the bench can check results without poking hierarchy. It consumes the processor's done output and the data-memory read port that the processor leaves idle once finished.

---
 rtl/mem_dump_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_dump_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: post-run memory readout stage.
// On a rising edge of the processor done flag it walks dump_len bytes of data
// memory starting at dump_base through a one-cycle-latency read port, streams
// each byte over a valid/ready interface and keeps a running 8-bit checksum.
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   done_in               processor done flag; its rising edge starts a dump
//   dump_base, dump_len   window start and byte count, sampled at start
//   mem_addr, mem_rd_en   read port request (mem_addr follows cur_addr)
//   mem_rd_data           read data, valid the cycle after mem_rd_en
//   out_data, out_valid,
//   out_last, out_ready   byte stream, out_last tags the final byte
//   dump_done             high from dump completion until done_in falls
//   checksum              modulo-2^DATA_W sum of every byte sent
module mem_dump_unit #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              done_in,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [LEN_W-1:0]  dump_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              dump_done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_CAPT   = 3'd2,
        S_SEND   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e             state_q,     state_d;
    logic [ADDR_W-1:0]  cur_addr_q,  cur_addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [DATA_W-1:0]  checksum_q,  checksum_d;
    logic               rd_en_q,     rd_en_d;
    logic               valid_q,     valid_d;
    logic               last_q,      last_d;
    logic               done_out_q,  done_out_d;
    logic               done_q;
    logic               start;

    // Only a fresh rising edge of done_in starts a dump
    assign start = done_in && !done_q;

    // Next-state and registered-output values
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;
        rd_en_d     = 1'b0;
        valid_d     = valid_q;
        last_d      = last_q;
        done_out_d  = done_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_addr_d  = dump_base;
                    remaining_d = dump_len;
                    checksum_d  = '0;
                    if (dump_len == '0) begin
                        state_d    = S_FINISH;
                        done_out_d = 1'b1;
                    end else begin
                        // Strobe is registered, so raise it on entry to ADDR
                        state_d = S_ADDR;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                out_data_d  = mem_rd_data;
                valid_d     = 1'b1;
                last_d      = (remaining_q == LEN_W'(1));
                checksum_d  = checksum_q + mem_rd_data;
                cur_addr_d  = cur_addr_q + ADDR_W'(1);
                remaining_d = remaining_q - LEN_W'(1);
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (remaining_q == '0) begin
                        state_d    = S_FINISH;
                        done_out_d = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                        rd_en_d = 1'b1;
                    end
                end
            end
            S_FINISH: begin
                if (!done_in) begin
                    done_out_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
            rd_en_q     <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_out_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
            rd_en_q     <= rd_en_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_out_q  <= done_out_d;
            done_q      <= done_in;
        end
    end

    assign mem_addr  = cur_addr_q;
    assign mem_rd_en = rd_en_q;
    assign out_data  = out_data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign dump_done = done_out_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// tb_mem_dump_unit: directed bench for mem_dump_unit with a synchronous
// one-cycle-latency memory model and a monitor logging reads and accepted bytes.
module tb_mem_dump_unit;

    logic       CLK;
    logic       RESET;
    logic       done_in;
    logic [7:0] dump_base;
    logic [8:0] dump_len;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       dump_done;
    logic [7:0] checksum;

    mem_dump_unit #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .done_in     (done_in),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .dump_done   (dump_done),
        .checksum    (checksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data memory: read data appears the cycle after the strobe
    logic [7:0] mem [256];
    initial mem_rd_data = 8'h00;
    always @(posedge CLK) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Monitor: read addresses, accepted bytes with their cycle, valid cycles
    int         cyc       = 0;
    int         rd_cnt    = 0;
    int         valid_cnt = 0;
    logic [7:0] rd_addr  [$];
    logic [7:0] acc_data [$];
    logic       acc_last [$];
    int         acc_cyc  [$];

    always @(posedge CLK) begin
        cyc++;
        if (mem_rd_en) begin
            rd_cnt++;
            rd_addr.push_back(mem_addr);
        end
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_last.push_back(out_last);
            acc_cyc.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !dump_done; i++) tick();
        check(tag, 32'(dump_done), 32'd1);
    endtask

    int a0, r0, ar0, v0, bad, lasts;

    initial begin
        RESET     = 1'b0;
        done_in   = 1'b0;
        dump_base = 8'h00;
        dump_len  = 9'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_rd_en",   32'(mem_rd_en), 32'd0);
        check("rst_done",    32'(dump_done), 32'd0);
        check("rst_csum",    32'(checksum),  32'd0);
        check("rst_data",    32'(out_data),  32'd0);
        check("rst_last",    32'(out_last),  32'd0);
        check("rst_addr",    32'(mem_addr),  32'd0);
        RESET = 1'b1;
        tick();

        // Basic dump: 05, 0A, FF from 0x10
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h0A; mem[8'h12] = 8'hFF;
        dump_base = 8'h10; dump_len = 9'd3;
        a0 = acc_data.size(); r0 = rd_cnt;
        done_in = 1'b1;
        tick();
        check("t1_rd_en_hi", 32'(mem_rd_en), 32'd1);
        check("t1_addr0",    32'(mem_addr),  32'h10);
        tick();
        check("t1_rd_en_lo", 32'(mem_rd_en), 32'd0);
        check("t1_valid_lo", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_hi", 32'(out_valid), 32'd1);
        check("t1_first",    32'(out_data),  32'h05);
        check("t1_first_lst",32'(out_last),  32'd0);
        wait_done(40, "t1_timeout");
        check("t1_count", 32'(acc_data.size() - a0), 32'd3);
        if (acc_data.size() - a0 == 3) begin
            check("t1_b0", 32'(acc_data[a0]),   32'h05);
            check("t1_b1", 32'(acc_data[a0+1]), 32'h0A);
            check("t1_b2", 32'(acc_data[a0+2]), 32'hFF);
            check("t1_l0", 32'(acc_last[a0]),   32'd0);
            check("t1_l1", 32'(acc_last[a0+1]), 32'd0);
            check("t1_l2", 32'(acc_last[a0+2]), 32'd1);
            check("t1_gap01", 32'(acc_cyc[a0+1] - acc_cyc[a0]),   32'd3);
            check("t1_gap12", 32'(acc_cyc[a0+2] - acc_cyc[a0+1]), 32'd3);
        end
        check("t1_csum",  32'(checksum), 32'h0E);
        check("t1_reads", 32'(rd_cnt - r0), 32'd3);

        // done_in held high: no retrigger
        r0 = rd_cnt;
        repeat (10) tick();
        check("hold_reads", 32'(rd_cnt - r0), 32'd0);
        check("hold_done",  32'(dump_done),   32'd1);
        check("hold_csum",  32'(checksum),    32'h0E);
        done_in = 1'b0;
        tick();
        check("t1_done_clr", 32'(dump_done), 32'd0);

        // Address wrap: FE, FF, 00, 01
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        dump_base = 8'hFE; dump_len = 9'd4;
        a0 = acc_data.size(); ar0 = rd_addr.size();
        done_in = 1'b1;
        tick();
        wait_done(60, "t2_timeout");
        check("t2_count", 32'(acc_data.size() - a0), 32'd4);
        check("t2_nrd",   32'(rd_addr.size() - ar0), 32'd4);
        if (acc_data.size() - a0 == 4 && rd_addr.size() - ar0 == 4) begin
            check("t2_a0", 32'(rd_addr[ar0]),   32'hFE);
            check("t2_a1", 32'(rd_addr[ar0+1]), 32'hFF);
            check("t2_a2", 32'(rd_addr[ar0+2]), 32'h00);
            check("t2_a3", 32'(rd_addr[ar0+3]), 32'h01);
            check("t2_b0", 32'(acc_data[a0]),   32'h11);
            check("t2_b3", 32'(acc_data[a0+3]), 32'h44);
            check("t2_l2", 32'(acc_last[a0+2]), 32'd0);
            check("t2_l3", 32'(acc_last[a0+3]), 32'd1);
        end
        check("t2_csum", 32'(checksum), 32'hAA);
        done_in = 1'b0;
        tick();

        // Backpressure: ready low for 5 cycles in the first SEND
        mem[8'h20] = 8'h3C; mem[8'h21] = 8'hC3;
        dump_base = 8'h20; dump_len = 9'd2;
        out_ready = 1'b0;
        a0 = acc_data.size(); r0 = rd_cnt;
        done_in = 1'b1;
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("t3_valid_up", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_data",  32'(out_data),  32'h3C);
            check("t3_hold_last",  32'(out_last),  32'd0);
        end
        check("t3_reads_held", 32'(rd_cnt - r0), 32'd1);
        out_ready = 1'b1;
        wait_done(40, "t3_timeout");
        check("t3_count", 32'(acc_data.size() - a0), 32'd2);
        if (acc_data.size() - a0 == 2) begin
            check("t3_b0", 32'(acc_data[a0]),   32'h3C);
            check("t3_b1", 32'(acc_data[a0+1]), 32'hC3);
            check("t3_l0", 32'(acc_last[a0]),   32'd0);
            check("t3_l1", 32'(acc_last[a0+1]), 32'd1);
        end
        check("t3_csum",  32'(checksum), 32'hFF);
        check("t3_reads", 32'(rd_cnt - r0), 32'd2);
        done_in = 1'b0;
        tick();

        // Zero length
        dump_base = 8'h40; dump_len = 9'd0;
        r0 = rd_cnt; v0 = valid_cnt;
        done_in = 1'b1;
        tick();
        check("t4_done", 32'(dump_done), 32'd1);
        check("t4_csum", 32'(checksum),  32'd0);
        tick();
        check("t4_reads", 32'(rd_cnt - r0),    32'd0);
        check("t4_valid", 32'(valid_cnt - v0), 32'd0);
        done_in = 1'b0;
        tick();

        // Reset during the second byte's SEND
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h0A; mem[8'h12] = 8'hFF;
        dump_base = 8'h10; dump_len = 9'd3;
        a0 = acc_data.size();
        done_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (acc_data.size() - a0 >= 1 && out_valid) break;
        end
        check("t5_second", 32'(out_data), 32'h0A);
        #2;
        RESET = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data",  32'(out_data),  32'd0);
        check("t5_last",  32'(out_last),  32'd0);
        check("t5_csum",  32'(checksum),  32'd0);
        check("t5_addr",  32'(mem_addr),  32'd0);
        check("t5_rd_en", 32'(mem_rd_en), 32'd0);
        check("t5_done",  32'(dump_done), 32'd0);
        done_in = 1'b0;
        tick();
        RESET = 1'b1;
        r0 = rd_cnt;
        repeat (3) tick();
        check("t5_idle_reads", 32'(rd_cnt - r0), 32'd0);

        // Full memory: mem[i] = i, 256 bytes
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        dump_base = 8'h00; dump_len = 9'd256;
        a0 = acc_data.size();
        done_in = 1'b1;
        tick();
        wait_done(900, "t6_timeout");
        check("t6_count", 32'(acc_data.size() - a0), 32'd256);
        if (acc_data.size() - a0 == 256) begin
            bad = 0; lasts = 0;
            for (int i = 0; i < 256; i++) begin
                if (acc_data[a0+i] !== 8'(i)) bad++;
                if (acc_last[a0+i]) lasts++;
            end
            check("t6_bad_bytes", 32'(bad),   32'd0);
            check("t6_last_cnt",  32'(lasts), 32'd1);
            check("t6_last_pos",  32'(acc_last[a0+255]), 32'd1);
        end
        check("t6_csum", 32'(checksum), 32'h80);
        done_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
